// File: rtl/common_types_pkg.sv
// Shared core types: word/register widths and the divider's operation and state encodings.
package common_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        DIV_S = 2'd0,
        DIV_U = 2'd1,
        REM_S = 2'd2,
        REM_U = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    function automatic logic div_op_signed(input div_op_t op);
        return (op == DIV_S) || (op == REM_S);
    endfunction

    function automatic logic div_op_is_rem(input div_op_t op);
        return (op == REM_S) || (op == REM_U);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on the {rem, quo} pair; purely combinational.
module div_restore_step
    import common_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] rem_i,
    input  logic [WORD_W-1:0] quo_i,
    input  logic [WORD_W-1:0] divisor_i,
    output logic [WORD_W-1:0] rem_c_o,
    output logic [WORD_W-1:0] quo_c_o
);

    logic [WORD_W:0] rem_sh;
    logic [WORD_W:0] trial;

    // Shifted partial remainder is always below 2*divisor, so W+1 bits hold the trial sign.
    always_comb begin
        rem_sh = {rem_i, quo_i[WORD_W-1]};
        trial  = rem_sh - {1'b0, divisor_i};
        if (!trial[WORD_W]) begin
            rem_c_o = trial[WORD_W-1:0];
            quo_c_o = {quo_i[WORD_W-2:0], 1'b1};
        end else begin
            rem_c_o = rem_sh[WORD_W-1:0];
            quo_c_o = {quo_i[WORD_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in EXECUTE; drives div_ready to the hazard unit.
// Optional: DIV_FAST_SPECIAL_EN resolves divide-by-zero and signed overflow in a single cycle.
module div_unit
    import common_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_en,
    input  div_op_t           div_op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              advance,
    input  logic              flush,
    output logic [WORD_W-1:0] result,
    output logic              div_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(WORD_W) + 1;

    div_state_t        state_q;
    div_op_t           op_q;
    logic [WORD_W-1:0] rem_q;
    logic [WORD_W-1:0] quo_q;
    logic [WORD_W-1:0] divisor_q;
    logic              sign_quo_q;
    logic              sign_rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] result_q;
    logic              ready_q;
    logic              busy_q;

    logic              op_signed_c;
    logic [WORD_W-1:0] a_abs_c;
    logic [WORD_W-1:0] b_abs_c;
    logic              sign_quo_c;
    logic              sign_rem_c;
    logic              special_c;
    logic [WORD_W-1:0] special_res_c;
    logic [WORD_W-1:0] rem_d;
    logic [WORD_W-1:0] quo_d;
    logic [WORD_W-1:0] quo_fix_c;
    logic [WORD_W-1:0] rem_fix_c;

    // Operand conditioning at start: magnitudes and result signs for signed ops.
    always_comb begin
        op_signed_c = div_op_signed(div_op);
        a_abs_c     = a;
        b_abs_c     = b;
        if (op_signed_c && a[WORD_W-1]) begin
            a_abs_c = -a;
        end
        if (op_signed_c && b[WORD_W-1]) begin
            b_abs_c = -b;
        end
        sign_quo_c = op_signed_c & (a[WORD_W-1] ^ b[WORD_W-1]);
        sign_rem_c = op_signed_c & a[WORD_W-1];
    end

`ifdef DIV_FAST_SPECIAL_EN
    localparam logic [WORD_W-1:0] MIN_NEG = {1'b1, {(WORD_W-1){1'b0}}};

    // Architectural results for the two cases the iteration would otherwise grind through.
    always_comb begin
        special_c     = 1'b0;
        special_res_c = '0;
        if (b == '0) begin
            special_c     = 1'b1;
            special_res_c = div_op_is_rem(div_op) ? a : '1;
        end else if (op_signed_c && (a == MIN_NEG) && (b == '1)) begin
            special_c     = 1'b1;
            special_res_c = div_op_is_rem(div_op) ? '0 : MIN_NEG;
        end
    end
`else
    assign special_c     = 1'b0;
    assign special_res_c = '0;
`endif

    div_restore_step #(
        .WORD_W (WORD_W)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_c_o   (rem_d),
        .quo_c_o   (quo_d)
    );

    // Sign fix-up; a zero divisor keeps the all-ones quotient unsigned.
    always_comb begin
        quo_fix_c = quo_q;
        rem_fix_c = rem_q;
        if (sign_quo_q && (divisor_q != '0)) begin
            quo_fix_c = -quo_q;
        end
        if (sign_rem_q) begin
            rem_fix_c = -rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            op_q       <= DIV_U;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (flush) begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (div_en) begin
                        op_q       <= div_op;
                        quo_q      <= a_abs_c;
                        divisor_q  <= b_abs_c;
                        sign_quo_q <= sign_quo_c;
                        sign_rem_q <= sign_rem_c;
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(WORD_W);
                        if (special_c) begin
                            result_q <= special_res_c;
                            ready_q  <= 1'b1;
                            state_q  <= DIV_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    result_q <= div_op_is_rem(op_q) ? rem_fix_c : quo_fix_c;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (advance) begin
                        ready_q <= 1'b0;
                        state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign div_ready = ready_q;
    assign busy      = busy_q;

endmodule
